// File: rtl/soc_bus_pkg.sv
// ---------------------------------------------------------------------------
// soc_bus_pkg
// Shared definitions for the SoC memory arbiter: FSM encoding, the default
// read-error pattern and width helpers for the pointer and timeout counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package soc_bus_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } state_t;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  // Width of the round-robin pointer / winner index for nm masters
  function automatic int ptr_w(input int nm);
    return (nm > 1) ? $clog2(nm) : 1;
  endfunction

  // Width of a counter that must hold 0 .. to-1
  function automatic int cnt_w(input int to);
    return (to > 1) ? $clog2(to) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Picks one requester per cycle, either round-robin starting from an internal
// pointer or fixed priority (index 0 highest). The pointer only moves when the
// caller reports that the winner's transfer was actually accepted.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import soc_bus_pkg::*;
#(
  parameter int NM      = 3,
  parameter bit RR_MODE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NM-1:0]           req,
  input  logic                    advance,
  output logic [NM-1:0]           gnt,
  output logic [ptr_w(NM)-1:0]    winner_idx
);

  localparam int PW = ptr_w(NM);

  logic [PW-1:0] ptr;
  logic [PW-1:0] start;
  logic [PW-1:0] idx;
  logic          found;
  int            pos;

  // Search requesters from the start index, wrapping modulo NM; first hit wins
  always_comb begin
    gnt        = '0;
    winner_idx = '0;
    found      = 1'b0;
    pos        = 0;
    idx        = '0;
    start      = RR_MODE ? ptr : '0;
    for (int i = 0; i < NM; i++) begin
      pos = int'(start) + i;
      if (pos >= NM) pos = pos - NM;
      idx = PW'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        winner_idx = idx;
      end
    end
  end

  // Pointer moves to the slot after the accepted winner; frozen in fixed mode
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance && RR_MODE) begin
      ptr <= (winner_idx == PW'(NM - 1)) ? '0 : winner_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/soc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// soc_mem_arbiter
// N-master to single-memory arbiter. Writes pass straight through and may be
// issued every cycle; a read blocks the bus until the memory answers or the
// timeout fires, and the response is routed back to the master that issued it.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module soc_mem_arbiter
  import soc_bus_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter int            NM       = 3,
  parameter bit            RR_MODE  = 1'b1,
  parameter int            TIMEOUT  = 64,
  parameter logic [DW-1:0] ERR_DATA = DW'(DEF_ERR_DATA)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NM-1:0]      m_req,
  input  logic [NM-1:0]      m_we,
  input  logic [NM*AW-1:0]   m_addr,
  input  logic [NM*DW-1:0]   m_wdata,
  output logic [NM-1:0]      m_gnt,
  output logic [NM-1:0]      m_rvalid,
  output logic [DW-1:0]      m_rdata,
  output logic [NM-1:0]      m_err,
  output logic               s_req,
  output logic               s_we,
  output logic [AW-1:0]      s_addr,
  output logic [DW-1:0]      s_wdata,
  input  logic               s_gnt,
  input  logic               s_rvalid,
  input  logic [DW-1:0]      s_rdata
);

  localparam int            PW       = ptr_w(NM);
  localparam int            CW       = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] owner;
  logic [CW-1:0] tmo_cnt;

  logic [NM-1:0] arb_gnt;
  logic [PW-1:0] win;
  logic          accept;
  logic          accept_rd;
  logic          rd_done;
  logic          rd_tmo;
  logic [NM-1:0] owner_oh;

  logic [AW-1:0] addr_arr  [NM];
  logic [DW-1:0] wdata_arr [NM];

  for (genvar g = 0; g < NM; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr[g*AW +: AW];
    assign wdata_arr[g] = m_wdata[g*DW +: DW];
  end

  rr_arbiter #(
    .NM      (NM),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk        (clk),
    .rstn       (rstn),
    .req        (m_req),
    .advance    (accept),
    .gnt        (arb_gnt),
    .winner_idx (win)
  );

  // Transfer and response qualifiers shared by FSM, counter and outputs
  always_comb begin
    accept    = (state == IDLE) && (|m_req) && s_gnt;
    accept_rd = accept && !m_we[win];
    rd_done   = (state == WAIT_RD) && s_rvalid;
    rd_tmo    = (state == WAIT_RD) && !s_rvalid && (tmo_cnt == TMO_LAST);
    owner_oh  = {{(NM-1){1'b0}}, 1'b1} << owner;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: only an accepted read leaves IDLE; response or timeout returns
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_rd)          state_nxt = WAIT_RD;
      WAIT_RD: if (rd_done || rd_tmo)  state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Remember who owns the outstanding read and how long it has been waiting
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner   <= '0;
      tmo_cnt <= '0;
    end else if (accept_rd) begin
      owner   <= win;
      tmo_cnt <= '0;
    end else if (state == WAIT_RD) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Outputs: bus request and grants in IDLE only, responses in WAIT_RD only
  always_comb begin
    s_we     = m_we[win];
    s_addr   = addr_arr[win];
    s_wdata  = wdata_arr[win];
    s_req    = 1'b0;
    m_gnt    = '0;
    m_rvalid = '0;
    m_err    = '0;
    m_rdata  = '0;
    if (state == IDLE) begin
      s_req = |m_req;
      m_gnt = s_gnt ? arb_gnt : '0;
    end
    if (rd_done) begin
      m_rvalid = owner_oh;
      m_rdata  = s_rdata;
    end else if (rd_tmo) begin
      m_rvalid = owner_oh;
      m_err    = owner_oh;
      m_rdata  = ERR_DATA;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_soc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_soc_mem_arbiter
// Drives one round-robin and one fixed-priority arbiter with shared stimulus
// and checks grants, muxed addresses and read responses against expectations
// queued at the time the stimulus is applied.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_soc_mem_arbiter;

  localparam int NM  = 3;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NM-1:0]     m_req = '0;
  logic [NM-1:0]     m_we = '0;
  logic [NM*AW-1:0]  m_addr = '0;
  logic [NM*DW-1:0]  m_wdata = '0;
  logic              s_gnt = 1'b0;
  logic              s_rvalid = 1'b0;
  logic [DW-1:0]     s_rdata = '0;

  logic [NM-1:0] gnt_r, rvalid_r, err_r, gnt_f, rvalid_f, err_f;
  logic [DW-1:0] rdata_r, wdata_r, rdata_f, wdata_f;
  logic [AW-1:0] addr_r, addr_f;
  logic          sreq_r, swe_r, sreq_f, swe_f;

  typedef struct {
    logic [NM-1:0] vld;
    logic [DW-1:0] data;
    logic [NM-1:0] err;
    int            cyc;
  } rsp_t;

  rsp_t rsp_q[$];
  int   wq_r[$];
  int   wq_f[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  soc_mem_arbiter #(.DW(DW), .AW(AW), .NM(NM), .RR_MODE(1'b1), .TIMEOUT(TMO), .ERR_DATA(ERRD)) u_dut_rr (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(gnt_r), .m_rvalid(rvalid_r), .m_rdata(rdata_r), .m_err(err_r),
    .s_req(sreq_r), .s_we(swe_r), .s_addr(addr_r), .s_wdata(wdata_r),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  soc_mem_arbiter #(.DW(DW), .AW(AW), .NM(NM), .RR_MODE(1'b0), .TIMEOUT(TMO), .ERR_DATA(ERRD)) u_dut_fp (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(gnt_f), .m_rvalid(rvalid_f), .m_rdata(rdata_f), .m_err(err_f),
    .s_req(sreq_f), .s_we(swe_f), .s_addr(addr_f), .s_wdata(wdata_f),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NM-1:0] oh(input int i);
    logic [NM-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; m_req = '0; m_we = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One read by master m. If respond, memory answers lat cycles after
  // acceptance; otherwise the timeout response is expected. side_req issues
  // writes from other masters while the read is outstanding.
  task automatic do_read(input int m, input int lat, input logic [31:0] d,
                         input bit respond, input logic [NM-1:0] side_req);
    rsp_t exp_r;
    rsp_t got;
    bit   seen;
    @(negedge clk);
    m_req = oh(m); m_we = '0; s_gnt = 1'b1; s_rvalid = 1'b0;
    #1;
    check_val("rd_gnt", gnt_r, oh(m));
    check_val("rd_swe", swe_r, 0);
    exp_r.vld  = oh(m);
    exp_r.data = respond ? d : ERRD;
    exp_r.err  = respond ? '0 : oh(m);
    exp_r.cyc  = respond ? lat : TMO;
    rsp_q.push_back(exp_r);
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      m_req = side_req; m_we = side_req;
      s_rvalid = respond && (k == lat);
      s_rdata  = (respond && k == lat) ? d : (32'h5555_0000 | k);
      #1;
      check_val("wait_gnt", gnt_r, 0);
      check_val("wait_sreq", sreq_r, 0);
      if (rvalid_r != 0) begin
        seen = 1'b1;
        got = rsp_q.pop_front();
        check_val("rsp_vld", rvalid_r, got.vld);
        check_val("rsp_data", rdata_r, got.data);
        check_val("rsp_err", err_r, got.err);
        check_val("rsp_cyc", k, got.cyc);
      end else begin
        check_val("wait_rdata", rdata_r, 0);
        check_val("wait_err", err_r, 0);
      end
    end
    if (!seen) begin
      check_val("rsp_missing", 0, 1);
      void'(rsp_q.pop_front());
    end
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    check_val("post_gnt", gnt_r, side_req);
    @(negedge clk);
    m_req = '0; m_we = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p_model;
    int w;
    logic [NM-1:0] r;
    // Reset state
    @(negedge clk);
    #1;
    check_val("rst_gnt", gnt_r, 0);
    check_val("rst_rvalid", rvalid_r, 0);
    check_val("rst_err", err_r, 0);
    check_val("rst_rdata", rdata_r, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Single write from master 1
    @(negedge clk);
    m_addr = '0; m_addr[1*AW +: AW] = 32'h10;
    m_wdata = '0; m_wdata[1*DW +: DW] = 32'h1234;
    m_req = 3'b010; m_we = 3'b010; s_gnt = 1'b1;
    #1;
    check_val("wr1_gnt", gnt_r, 3'b010);
    check_val("wr1_addr", addr_r, 32'h10);
    check_val("wr1_wdata", wdata_r, 32'h1234);
    check_val("wr1_sreq", sreq_r, 1);
    check_val("wr1_swe", swe_r, 1);
    check_val("wr1_rvalid", rvalid_r, 0);
    @(negedge clk);
    m_req = '0;
    #1;
    check_val("wr1_rvalid2", rvalid_r, 0);

    // Continuous contention: RR rotates 0,1,2; fixed priority starves 1 and 2
    do_reset();
    m_addr = {32'h200, 32'h100, 32'h000};
    for (int c = 0; c < 6; c++) begin
      wq_r.push_back(c % 3);
      wq_f.push_back(0);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      m_req = 3'b111; m_we = 3'b111; s_gnt = 1'b1;
      #1;
      w = wq_r.pop_front();
      check_val("rr_gnt", gnt_r, oh(w));
      check_val("rr_addr", addr_r, w * 32'h100);
      w = wq_f.pop_front();
      check_val("fp_gnt", gnt_f, oh(w));
    end

    // Random requests and memory back-pressure, writes only
    do_reset();
    p_model = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      r = NM'($urandom_range(0, 7));
      m_req = r; m_we = 3'b111;
      s_gnt = ($urandom_range(0, 3) != 0);
      w = -1;
      for (int i = 0; i < NM; i++)
        if (w < 0 && r[(p_model + i) % NM]) w = (p_model + i) % NM;
      wq_r.push_back(w);
      w = -1;
      for (int i = NM - 1; i >= 0; i--) if (r[i]) w = i;
      wq_f.push_back(w);
      #1;
      w = wq_r.pop_front();
      check_val("rnd_rr_gnt", gnt_r, (s_gnt && w >= 0) ? oh(w) : '0);
      check_val("rnd_sreq", sreq_r, r != 0);
      if (s_gnt && w >= 0) p_model = (w + 1) % NM;
      w = wq_f.pop_front();
      check_val("rnd_fp_gnt", gnt_f, (s_gnt && w >= 0) ? oh(w) : '0);
    end
    @(negedge clk);
    m_req = '0;

    // Reads: normal response, timeout, and response on the timeout cycle
    do_read(2, 3, 32'hCAFE_0001, 1'b1, 3'b001);
    do_read(0, 0, 32'h0, 1'b0, 3'b000);
    @(negedge clk);
    s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
    #1;
    check_val("late_rvalid", rvalid_r, 0);
    check_val("late_rdata", rdata_r, 0);
    @(negedge clk);
    s_rvalid = 1'b0;
    do_read(1, TMO, 32'h0BAD_F00D, 1'b1, 3'b000);
    do_read(1, 1, 32'h0000_0042, 1'b1, 3'b000);

    // Reset while a read is outstanding
    @(negedge clk);
    m_req = 3'b010; m_we = '0; s_gnt = 1'b1;
    #1;
    check_val("mr_gnt", gnt_r, 3'b010);
    @(negedge clk);
    m_req = '0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_val("mr_rst_rvalid", rvalid_r, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    s_rvalid = 1'b1; s_rdata = 32'h7777_7777;
    #1;
    check_val("mr_stray_rvalid", rvalid_r, 0);
    check_val("mr_stray_err", err_r, 0);
    @(negedge clk);
    s_rvalid = 1'b0; m_req = 3'b111; m_we = 3'b111; s_gnt = 1'b1;
    #1;
    check_val("mr_rr_gnt", gnt_r, 3'b001);
    check_val("mr_fp_gnt", gnt_f, 3'b001);
    @(negedge clk);
    m_req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
